vm2002_change_ctrl: RTL and testbench
=====================================

# vm2002_change_ctrl

Change-dispense controller for the vm2002 vending machine. After a vend, or a soft-reset refund, it takes the balance owed, in cents, and pays it out from an internal coin inventory: quarters, dimes and nickels. It drives a coin hopper one coin at a time over a req/ack handshake. It tracks the inventory, which the supplier refills, and reports completion, inability to make change, and hopper timeout to the vm2002 top-level FSM.

## Interface
Parameters:
- AMT_W, 8: width of amount in cents (max 255).
- CNT_W, 4: width of each coin inventory counter (max 15 coins per type).
- ACK_TIMEOUT, 16: cycles hopper_req may stay high without hopper_ack before abort.

Ports:
- clk  in  1  clock; all logic on rising edge.
- hrst  in  1  hard reset; synchronous, active-high; clears everything including inventory.
- srst  in  1  soft reset; synchronous, active-high; aborts the payout and preserves inventory.
- start  in  1  one-cycle request to pay `balance`; sampled only in IDLE.
- balance  in  AMT_W  amount owed, in cents.
- load  in  1  supplier refill strobe; honoured only in IDLE.
- load_coin  in  2  coin code: 1=nickel(5), 2=dime(10), 3=quarter(25); 0=ignored.
- load_count  in  CNT_W  coins to add.
- hopper_req  out  1  coin eject request.
- hopper_coin  out  2  coin code to eject; valid while hopper_req=1.
- hopper_ack  in  1  hopper ejected the coin; sampled while hopper_req=1.
- busy  out  1  high in all states except IDLE.
- done  out  1  one-cycle pulse: full balance paid.
- exact_fail  out  1  one-cycle pulse: cannot make exact change.
- timeout_err  out  1  one-cycle pulse: hopper did not ack.
- remaining  out  AMT_W  amount still owed; holds its value after DONE, FAIL or ERR until the next start.
- inv_n, inv_d, inv_q  out  CNT_W each  nickel, dime and quarter inventory.

## Operation
- States: IDLE, SELECT, WAIT, DONE, FAIL, ERR.
- Reset priority: hrst > srst > everything else.
- hrst: state=IDLE; all outputs 0; inventory=0; timer=0.
- srst: state=IDLE; hopper_req=0; no status pulse. Inventory and remaining keep their values.
- IDLE behaviour:
  - load with a nonzero load_coin adds load_count to that counter, saturating at 2^CNT_W-1.
  - start latches remaining=balance. If balance%5 != 0, go to FAIL; otherwise go to SELECT.
  - If start and load occur in the same cycle, both take effect. SELECT then sees the updated inventory.
- SELECT, with hopper_req=0:
  - remaining==0: go to DONE.
  - Otherwise pick greedily, largest first: quarter if remaining>=25 and inv_q>0; else dime if remaining>=10 and inv_d>0; else nickel if inv_n>0. Register hopper_coin, set hopper_req=1, clear the timer, and go to WAIT.
  - No coin is eligible: go to FAIL.
- Greedy selection is normative. Greedy failures that a non-greedy choice could avoid must still report FAIL.
- WAIT, with hopper_req=1 and hopper_coin stable:
  - hopper_ack=1: decrement the selected inventory counter, subtract the coin value from remaining, drop hopper_req, and go to SELECT.
  - hopper_ack=0 with timer==ACK_TIMEOUT-1: drop hopper_req and go to ERR. Neither inventory nor remaining is decremented.
  - Otherwise increment the timer.
- DONE, FAIL and ERR each last one cycle, pulse done, exact_fail or timeout_err respectively, and then return to IDLE.
- start is ignored while busy. load is ignored while busy and is not queued.
- hopper_ack outside WAIT is ignored.

## Timing
- The edge that samples start in IDLE is cycle 0. busy=1 from cycle 1, which is SELECT.
- hopper_req rises in cycle 2. An ack in the same cycle completes the coin, and cycle 3 is SELECT with req=0.
- Per coin: at least 2 cycles. hopper_req is low for at least one cycle between coins.
- Pulse timing for balance=0: done=1 in cycle 2, IDLE in cycle 3.
- Pulse timing for a non-multiple-of-5 balance: exact_fail=1 in cycle 1.
- Timeout: hopper_req stays high for exactly ACK_TIMEOUT cycles. timeout_err=1 in the following cycle.
- remaining and the inventory outputs update on the cycle after the ack.
- busy drops in the cycle after the DONE, FAIL or ERR pulse.

## Test plan
- Refill in IDLE: nickels 15, dimes 15, quarters 15. start with balance=65, hopper acks immediately. Required: hopper_coin sequence 3,3,2,1; then done; remaining=0; inv_q=13, inv_d=14, inv_n=14.
- Greedy failure: inventory q=1, d=3, n=0. start with balance=30. Required: one quarter ejected, then exact_fail; remaining=5; inv_q=0, inv_d=3.
- Hopper timeout: ack held low after the first req. Required: req high for exactly 16 cycles, then a timeout_err pulse; inventory unchanged; busy=0 the cycle after.
- srst during WAIT of the second coin, balance=50, two quarters. Required: req drops the next cycle; no done; inv_q has decremented by 1 only; remaining=25.
- Load while busy: load 5 dimes during a payout. Required: inv_d unchanged. Separately, loading 10 onto inv_n=10 in IDLE saturates at 15.
- balance=7. Required: exact_fail in cycle 1 and no hopper_req. balance=0: done in cycle 2.

Source files
------------

// File: rtl/vm2002_change_ctrl.sv
// vm2002_change_ctrl: greedy change dispenser driving a one-coin-at-a-time
// hopper over req/ack, with a saturating quarter/dime/nickel inventory.
module vm2002_change_ctrl #(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             hrst,
  input  logic             srst,
  input  logic             start,
  input  logic [AMT_W-1:0] balance,
  input  logic             load,
  input  logic [1:0]       load_coin,
  input  logic [CNT_W-1:0] load_count,
  output logic             hopper_req,
  output logic [1:0]       hopper_coin,
  input  logic             hopper_ack,
  output logic             busy,
  output logic             done,
  output logic             exact_fail,
  output logic             timeout_err,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] inv_n,
  output logic [CNT_W-1:0] inv_d,
  output logic [CNT_W-1:0] inv_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT,
    S_DONE,
    S_FAIL,
    S_ERR
  } state_e;

  localparam logic [1:0] COIN_N = 2'd1;
  localparam logic [1:0] COIN_D = 2'd2;
  localparam logic [1:0] COIN_Q = 2'd3;

  localparam int unsigned TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_q, coin_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] inv_n_q, inv_n_d;
  logic [CNT_W-1:0] inv_d_q, inv_d_d;
  logic [CNT_W-1:0] inv_q_q, inv_q_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_Q:  return AMT_W'(25);
      COIN_D:  return AMT_W'(10);
      COIN_N:  return AMT_W'(5);
      default: return '0;
    endcase
  endfunction

  // Next-state, refill, greedy selection and hopper handshake.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    timer_d     = timer_q;
    inv_n_d     = inv_n_q;
    inv_d_d     = inv_d_q;
    inv_q_d     = inv_q_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          case (load_coin)
            COIN_N:  inv_n_d = sat_add(inv_n_q, load_count);
            COIN_D:  inv_d_d = sat_add(inv_d_q, load_count);
            COIN_Q:  inv_q_d = sat_add(inv_q_q, load_count);
            default: ;
          endcase
        end
        if (start) begin
          remaining_d = balance;
          if ((balance % AMT_W'(5)) != '0) state_d = S_FAIL;
          else                             state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (remaining_q >= AMT_W'(25) && inv_q_q != '0) begin
          coin_d  = COIN_Q;
          timer_d = '0;
          state_d = S_WAIT;
        end else if (remaining_q >= AMT_W'(10) && inv_d_q != '0) begin
          coin_d  = COIN_D;
          timer_d = '0;
          state_d = S_WAIT;
        end else if (inv_n_q != '0) begin
          coin_d  = COIN_N;
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_FAIL;
        end
      end

      S_WAIT: begin
        if (hopper_ack) begin
          case (coin_q)
            COIN_N:  inv_n_d = inv_n_q - CNT_W'(1);
            COIN_D:  inv_d_d = inv_d_q - CNT_W'(1);
            COIN_Q:  inv_q_d = inv_q_q - CNT_W'(1);
            default: ;
          endcase
          remaining_d = remaining_q - coin_value(coin_q);
          state_d     = S_SELECT;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_DONE, S_FAIL, S_ERR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; soft reset keeps inventory and remaining.
  always_ff @(posedge clk) begin
    if (hrst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      coin_q      <= '0;
      timer_q     <= '0;
      inv_n_q     <= '0;
      inv_d_q     <= '0;
      inv_q_q     <= '0;
    end else if (srst) begin
      state_q <= S_IDLE;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      timer_q     <= timer_d;
      inv_n_q     <= inv_n_d;
      inv_d_q     <= inv_d_d;
      inv_q_q     <= inv_q_d;
    end
  end

  assign hopper_req  = (state_q == S_WAIT);
  assign hopper_coin = coin_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign exact_fail  = (state_q == S_FAIL);
  assign timeout_err = (state_q == S_ERR);
  assign remaining   = remaining_q;
  assign inv_n       = inv_n_q;
  assign inv_d       = inv_d_q;
  assign inv_q       = inv_q_q;

endmodule

// File: tb/tb_vm2002_change_ctrl.sv
// Directed bench for vm2002_change_ctrl with hand-computed expectations.
module tb_vm2002_change_ctrl;

  logic       clk;
  logic       hrst, srst, start, load, hopper_ack;
  logic [7:0] balance;
  logic [1:0] load_coin;
  logic [3:0] load_count;
  logic       hopper_req, busy, done, exact_fail, timeout_err;
  logic [1:0] hopper_coin;
  logic [7:0] remaining;
  logic [3:0] inv_n, inv_d, inv_q;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [1:0]  coins[$];
  int unsigned done_cnt, fail_cnt, err_cnt, req_cycles;
  int unsigned done_cyc, fail_cyc, err_cyc, end_cyc;
  logic        auto_ack;

  vm2002_change_ctrl #(
    .AMT_W(8),
    .CNT_W(4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .hrst       (hrst),
    .srst       (srst),
    .start      (start),
    .balance    (balance),
    .load       (load),
    .load_coin  (load_coin),
    .load_count (load_count),
    .hopper_req (hopper_req),
    .hopper_coin(hopper_coin),
    .hopper_ack (hopper_ack),
    .busy       (busy),
    .done       (done),
    .exact_fail (exact_fail),
    .timeout_err(timeout_err),
    .remaining  (remaining),
    .inv_n      (inv_n),
    .inv_d      (inv_d),
    .inv_q      (inv_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hrst();
    hrst = 1'b1;
    tick();
    tick();
    hrst = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] code, input logic [3:0] cnt);
    load       = 1'b1;
    load_coin  = code;
    load_count = cnt;
    tick();
    load       = 1'b0;
  endtask

  // Pulse start, then follow the payout cycle by cycle (cycle 1 = first after start).
  task automatic run_pay(input logic [7:0] bal, input logic ld_during);
    coins.delete();
    done_cnt = 0; fail_cnt = 0; err_cnt = 0; req_cycles = 0;
    done_cyc = 0; fail_cyc = 0; err_cyc = 0; end_cyc = 0;
    balance = bal;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    if (ld_during) begin
      load = 1'b1; load_coin = 2'd2; load_count = 4'd5;
    end
    for (int c = 1; c <= 100; c++) begin
      if (c == 1) chk("busy_cycle1", busy, 1);
      if (done)        begin done_cnt++; done_cyc = c; end
      if (exact_fail)  begin fail_cnt++; fail_cyc = c; end
      if (timeout_err) begin err_cnt++;  err_cyc  = c; end
      if (hopper_req) begin
        req_cycles++;
        if (auto_ack) coins.push_back(hopper_coin);
      end
      hopper_ack = hopper_req && auto_ack;
      if (!busy) begin
        end_cyc = c;
        break;
      end
      tick();
    end
    load       = 1'b0;
    hopper_ack = 1'b0;
    if (end_cyc == 0) chk("run_bound", 0, 1);
  endtask

  initial begin
    int unsigned seen_done;
    hrst = 0; srst = 0; start = 0; load = 0; hopper_ack = 0;
    balance = '0; load_coin = '0; load_count = '0; auto_ack = 1'b1;

    // Reset state
    do_hrst();
    chk("rst_busy", busy, 0);
    chk("rst_req", hopper_req, 0);
    chk("rst_done", done, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_inv_n", inv_n, 0);
    chk("rst_inv_d", inv_d, 0);
    chk("rst_inv_q", inv_q, 0);

    // Refill and pay 65 -> Q,Q,D,N
    do_load(2'd1, 4'd15);
    do_load(2'd2, 4'd15);
    do_load(2'd3, 4'd15);
    chk("load_inv_q", inv_q, 15);
    run_pay(8'd65, 1'b0);
    chk("p65_ncoins", coins.size(), 4);
    if (coins.size() == 4) begin
      chk("p65_coin0", coins[0], 3);
      chk("p65_coin1", coins[1], 3);
      chk("p65_coin2", coins[2], 2);
      chk("p65_coin3", coins[3], 1);
    end
    chk("p65_done_cnt", done_cnt, 1);
    chk("p65_done_cyc", done_cyc, 10);
    chk("p65_end_cyc", end_cyc, 11);
    chk("p65_rem", remaining, 0);
    chk("p65_inv_q", inv_q, 13);
    chk("p65_inv_d", inv_d, 14);
    chk("p65_inv_n", inv_n, 14);

    // Greedy failure: q=1 d=3 n=0, balance 30
    do_hrst();
    do_load(2'd3, 4'd1);
    do_load(2'd2, 4'd3);
    run_pay(8'd30, 1'b0);
    chk("g30_ncoins", coins.size(), 1);
    if (coins.size() == 1) chk("g30_coin0", coins[0], 3);
    chk("g30_fail_cnt", fail_cnt, 1);
    chk("g30_done_cnt", done_cnt, 0);
    chk("g30_rem", remaining, 5);
    chk("g30_inv_q", inv_q, 0);
    chk("g30_inv_d", inv_d, 3);

    // Hopper timeout on a dime
    auto_ack = 1'b0;
    run_pay(8'd10, 1'b0);
    auto_ack = 1'b1;
    chk("to_req_cycles", req_cycles, 16);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_err_cyc", err_cyc, 18);
    chk("to_end_cyc", end_cyc, 19);
    chk("to_inv_d", inv_d, 3);
    chk("to_rem", remaining, 10);

    // Soft reset during WAIT of the second quarter
    do_hrst();
    do_load(2'd3, 4'd2);
    balance = 8'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();                              // cycle 2
    chk("sr_req_c2", hopper_req, 1);
    hopper_ack = 1'b1;
    tick();                              // cycle 3
    hopper_ack = 1'b0;
    chk("sr_rem_c3", remaining, 25);
    tick();                              // cycle 4
    chk("sr_req_c4", hopper_req, 1);
    srst = 1'b1;
    tick();                              // cycle 5
    srst = 1'b0;
    chk("sr_req_after", hopper_req, 0);
    chk("sr_busy_after", busy, 0);
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) seen_done++;
      tick();
    end
    chk("sr_no_done", seen_done, 0);
    chk("sr_inv_q", inv_q, 1);
    chk("sr_rem", remaining, 25);

    // Load while busy is dropped; saturating load in IDLE
    do_hrst();
    do_load(2'd1, 4'd10);
    do_load(2'd2, 4'd1);
    run_pay(8'd10, 1'b1);
    chk("lb_done_cnt", done_cnt, 1);
    chk("lb_inv_d", inv_d, 0);
    chk("lb_inv_n", inv_n, 10);
    do_load(2'd1, 4'd10);
    chk("sat_inv_n", inv_n, 15);

    // start and load in the same cycle: SELECT sees the new quarter
    load = 1'b1; load_coin = 2'd3; load_count = 4'd1;
    run_pay(8'd25, 1'b0);
    chk("sl_ncoins", coins.size(), 1);
    if (coins.size() == 1) chk("sl_coin0", coins[0], 3);
    chk("sl_done_cnt", done_cnt, 1);
    chk("sl_inv_q", inv_q, 0);
    chk("sl_inv_n", inv_n, 15);

    // balance=7: immediate exact_fail, no hopper activity
    run_pay(8'd7, 1'b0);
    chk("b7_fail_cyc", fail_cyc, 1);
    chk("b7_req_cycles", req_cycles, 0);
    chk("b7_end_cyc", end_cyc, 2);
    chk("b7_rem", remaining, 7);

    // balance=0: done in cycle 2
    run_pay(8'd0, 1'b0);
    chk("b0_done_cyc", done_cyc, 2);
    chk("b0_req_cycles", req_cycles, 0);
    chk("b0_end_cyc", end_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
